// File: rtl/wbnpriarb.sv
// wbnpriarb: N-master pipelined Wishbone (B4) arbiter with global/local cycle lines.
// The grant is held for a master's whole cycle and parks on the last owner.
// An outstanding-request counter throttles the owner and drops stale acks.
// Build option: define ZIPARB_ROUNDROBIN_EN for round-robin arbitration
// (the default build uses fixed priority, lowest index wins).
module wbnpriarb #(
  parameter int unsigned NM               = 3,
  parameter int unsigned AW               = 30,
  parameter int unsigned DW               = 32,
  parameter int unsigned LGOUT            = 4,
  parameter bit          OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NM-1:0]           i_mcyc_gbl,
  input  logic [NM-1:0]           i_mcyc_lcl,
  input  logic [NM-1:0]           i_mstb_gbl,
  input  logic [NM-1:0]           i_mstb_lcl,
  input  logic [NM-1:0]           i_mwe,
  input  logic [NM*AW-1:0]        i_maddr,
  input  logic [NM*DW-1:0]        i_mdata,
  input  logic [NM*(DW/8)-1:0]    i_msel,
  output logic [NM-1:0]           o_mstall,
  output logic [NM-1:0]           o_mack,
  output logic [NM-1:0]           o_merr,
  output logic                    o_wb_gbl_cyc,
  output logic                    o_wb_lcl_cyc,
  output logic                    o_wb_gbl_stb,
  output logic                    o_wb_lcl_stb,
  output logic                    o_wb_we,
  output logic [AW-1:0]           o_wb_addr,
  output logic [DW-1:0]           o_wb_data,
  output logic [DW/8-1:0]         o_wb_sel,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  output logic [$clog2(NM)-1:0]   o_grant,
  output logic                    o_busy
);

  localparam int unsigned GW = $clog2(NM);
  localparam int unsigned SW = DW / 8;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StOwned = 1'b1;

  logic [GW-1:0]    owner_q, owner_d, winner;
  logic [0:0]       state_q, state_d;
  logic             rst_q;
  logic [LGOUT-1:0] cnt_q, cnt_d;

  logic [NM-1:0] req;
  logic          any_req, granted, active, full, accept, ack_fwd, err_fwd;
  logic          own_cyc_g, own_cyc_l, own_stb_g, own_stb_l, own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_data;
  logic [SW-1:0] own_sel;

  assign req     = i_mcyc_gbl | i_mcyc_lcl;
  assign any_req = |req;

  // Select the current owner's request signals
  always_comb begin
    own_cyc_g = 1'b0;
    own_cyc_l = 1'b0;
    own_stb_g = 1'b0;
    own_stb_l = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    own_sel   = '0;
    for (int k = 0; k < NM; k++) begin
      if (GW'(k) == owner_q) begin
        own_cyc_g = i_mcyc_gbl[k];
        own_cyc_l = i_mcyc_lcl[k];
        own_stb_g = i_mstb_gbl[k];
        own_stb_l = i_mstb_lcl[k];
        own_we    = i_mwe[k];
        own_addr  = i_maddr[k*AW +: AW];
        own_data  = i_mdata[k*DW +: DW];
        own_sel   = i_msel[k*SW +: SW];
      end
    end
  end

`ifdef ZIPARB_ROUNDROBIN_EN
  // Round robin: first requester after the owner, owner itself searched last
  always_comb begin
    winner = owner_q;
    for (int i = NM; i >= 1; i--) begin
      if (req[(int'(owner_q) + i) % NM]) winner = GW'((int'(owner_q) + i) % NM);
    end
  end
`else
  // Fixed priority: lowest requesting index wins
  always_comb begin
    winner = owner_q;
    for (int k = NM - 1; k >= 0; k--) begin
      if (req[k]) winner = GW'(k);
    end
  end
`endif

  // Owner passes through when frozen, or when it also wins arbitration while idle
  assign granted = (own_cyc_g | own_cyc_l) & ((state_q == StOwned) | (winner == owner_q));
  assign active  = granted & ~i_reset & ~rst_q;
  assign full    = &cnt_q;
  assign accept  = active & ~full & (own_stb_g | own_stb_l) & ~i_wb_stall;
  // Acks with nothing outstanding belong to an abandoned cycle
  assign ack_fwd = active & i_wb_ack & (cnt_q != '0);
  assign err_fwd = active & i_wb_err;

  // Bus-side pass-through
  always_comb begin
    o_wb_gbl_cyc = active & own_cyc_g;
    o_wb_lcl_cyc = active & own_cyc_l;
    o_wb_gbl_stb = active & ~full & own_stb_g;
    o_wb_lcl_stb = active & ~full & own_stb_l;
    if (OPT_ZERO_ON_IDLE && !active) begin
      o_wb_we   = 1'b0;
      o_wb_addr = '0;
      o_wb_data = '0;
      o_wb_sel  = '0;
    end else begin
      o_wb_we   = own_we;
      o_wb_addr = own_addr;
      o_wb_data = own_data;
      o_wb_sel  = own_sel;
    end
    o_grant = i_reset ? '0 : owner_q;
    o_busy  = active;
  end

  // Master-side stall and response routing
  always_comb begin
    o_mstall = '1;
    o_mack   = '0;
    o_merr   = '0;
    for (int k = 0; k < NM; k++) begin
      if (active && (GW'(k) == owner_q)) begin
        o_mstall[k] = i_wb_stall | full;
        o_mack[k]   = ack_fwd;
        o_merr[k]   = err_fwd;
      end
    end
  end

  // Next owner/state and outstanding count
  always_comb begin
    owner_d = owner_q;
    state_d = active ? StOwned : StIdle;
    // A newly chosen owner is reserved so it passes through on its next cycle
    if (!active && any_req && (winner != owner_q)) begin
      owner_d = winner;
      state_d = StOwned;
    end
    if (!active || i_wb_err) cnt_d = '0;
    else                     cnt_d = cnt_q + LGOUT'(accept) - LGOUT'(ack_fwd);
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_q <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
    end else begin
      owner_q <= owner_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wbnpriarb.sv
// tb_wbnpriarb: table-driven arbitration checks plus hand-written burst,
// throttle and error sequences; bus addresses checked against a scoreboard.
module tb_wbnpriarb;
  localparam int NM = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int LGOUT = 2;

  logic i_clk = 1'b0;
  logic i_reset;
  logic [NM-1:0] i_mcyc_gbl, i_mcyc_lcl, i_mstb_gbl, i_mstb_lcl, i_mwe;
  logic [NM*AW-1:0] i_maddr;
  logic [NM*DW-1:0] i_mdata;
  logic [NM*(DW/8)-1:0] i_msel;
  logic [NM-1:0] o_mstall, o_mack, o_merr;
  logic o_wb_gbl_cyc, o_wb_lcl_cyc, o_wb_gbl_stb, o_wb_lcl_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic i_wb_stall, i_wb_ack, i_wb_err;
  logic [1:0] o_grant;
  logic o_busy;

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [AW-1:0] exp_q[$];

  wbnpriarb #(.NM(NM), .AW(AW), .DW(DW), .LGOUT(LGOUT), .OPT_ZERO_ON_IDLE(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_mcyc_gbl(i_mcyc_gbl), .i_mcyc_lcl(i_mcyc_lcl),
    .i_mstb_gbl(i_mstb_gbl), .i_mstb_lcl(i_mstb_lcl), .i_mwe(i_mwe),
    .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
    .o_mstall(o_mstall), .o_mack(o_mack), .o_merr(o_merr),
    .o_wb_gbl_cyc(o_wb_gbl_cyc), .o_wb_lcl_cyc(o_wb_lcl_cyc),
    .o_wb_gbl_stb(o_wb_gbl_stb), .o_wb_lcl_stb(o_wb_lcl_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic [2:0] cg, cl, sg;
    logic [1:0] e_grant;
    logic       e_gcyc, e_lcyc, e_gstb;
    logic [2:0] e_mstall;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one request from master m and wait (bounded) until it is accepted
  task automatic issue(input int m, input logic [AW-1:0] a);
    logic done;
    done = 1'b0;
    i_maddr[m*AW +: AW] = a;
    i_mstb_gbl[m] = 1'b1;
    exp_q.push_back(a);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge i_clk);
      if (!o_mstall[m]) done = 1'b1;
      nxt();
    end
    chk("issue_accepted", {63'd0, done}, 64'd1);
  endtask

  // Bus monitor: each accepted bus request must match the next expected address
  always @(negedge i_clk) begin
    if (mon_en && o_wb_gbl_stb && !i_wb_stall) begin
      if (exp_q.size() == 0) chk("bus_unexpected_stb", 64'd1, 64'd0);
      else chk("bus_addr", {34'd0, o_wb_addr}, {34'd0, exp_q.pop_front()});
    end
  end

  vec_t vecs[19];
  int acks;

  initial begin
    //            rst  cg      cl      sg      grant gcyc lcyc gstb mstall
    vecs[0]  = '{1'b1, 3'b111, 3'b000, 3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[1]  = '{1'b0, 3'b111, 3'b000, 3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[2]  = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[3]  = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[4]  = '{1'b0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 1'b1, 3'b110};
    vecs[5]  = '{1'b0, 3'b001, 3'b000, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 3'b110};
    vecs[6]  = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[7]  = '{1'b0, 3'b100, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[8]  = '{1'b0, 3'b100, 3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 1'b0, 3'b011};
    vecs[9]  = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[10] = '{1'b0, 3'b011, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[11] = '{1'b0, 3'b011, 3'b000, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 3'b110};
    vecs[12] = '{1'b0, 3'b010, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[13] = '{1'b0, 3'b010, 3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 3'b101};
    vecs[14] = '{1'b0, 3'b000, 3'b001, 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[15] = '{1'b0, 3'b000, 3'b001, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 3'b110};
    vecs[16] = '{1'b0, 3'b010, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};
    vecs[17] = '{1'b0, 3'b010, 3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0, 3'b101};
    vecs[18] = '{1'b1, 3'b010, 3'b000, 3'b010, 2'd0, 1'b0, 1'b0, 1'b0, 3'b111};

    i_reset = 1'b1;
    i_mcyc_gbl = '0; i_mcyc_lcl = '0; i_mstb_gbl = '0; i_mstb_lcl = '0; i_mwe = '0;
    i_maddr = '0; i_mdata = '0; i_msel = '0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    nxt();

    // Arbitration, pass-through, handover and reset rows
    for (int r = 0; r < 19; r++) begin
      i_reset = vecs[r].rst;
      i_mcyc_gbl = vecs[r].cg;
      i_mcyc_lcl = vecs[r].cl;
      i_mstb_gbl = vecs[r].sg;
      @(negedge i_clk);
      chk($sformatf("v%0d_grant", r), {62'd0, o_grant}, {62'd0, vecs[r].e_grant});
      chk($sformatf("v%0d_gcyc", r), {63'd0, o_wb_gbl_cyc}, {63'd0, vecs[r].e_gcyc});
      chk($sformatf("v%0d_lcyc", r), {63'd0, o_wb_lcl_cyc}, {63'd0, vecs[r].e_lcyc});
      chk($sformatf("v%0d_gstb", r), {63'd0, o_wb_gbl_stb}, {63'd0, vecs[r].e_gstb});
      chk($sformatf("v%0d_mstall", r), {61'd0, o_mstall}, {61'd0, vecs[r].e_mstall});
      chk($sformatf("v%0d_mack_merr", r), {58'd0, o_mack, o_merr}, 64'd0);
      nxt();
    end
    // Cycle after the mid-cycle reset: still quiet, master 1 chosen behind it
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("post_rst_gcyc", {63'd0, o_wb_gbl_cyc}, 64'd0);
    chk("post_rst_mstall", {61'd0, o_mstall}, 64'h7);
    nxt();
    i_mcyc_gbl = '0; i_mstb_gbl = '0;
    nxt();

    // Park on master 0
    i_mcyc_gbl = 3'b001;
    nxt();
    @(negedge i_clk);
    chk("park0_grant", {62'd0, o_grant}, 64'd0);
    nxt();
    i_mcyc_gbl = 3'b000;
    nxt();

    // Master 2 requests alone: one stall cycle, then three pipelined reads
    mon_en = 1'b1;
    i_mcyc_gbl = 3'b100;
    i_mstb_gbl = 3'b100;
    i_maddr[2*AW +: AW] = 30'h0000_0a00;
    exp_q.push_back(30'h0000_0a00);
    @(negedge i_clk);
    chk("t2_wait_grant", {62'd0, o_grant}, 64'd0);
    chk("t2_wait_stall", {63'd0, o_mstall[2]}, 64'd1);
    chk("t2_wait_stb", {63'd0, o_wb_gbl_stb}, 64'd0);
    nxt();
    @(negedge i_clk);
    chk("t2_grant", {62'd0, o_grant}, 64'd2);
    chk("t2_stall", {63'd0, o_mstall[2]}, 64'd0);
    nxt();
    issue(2, 30'h0000_0a01);
    issue(2, 30'h0000_0a02);
    i_mstb_gbl = 3'b000;
    acks = 0;
    i_wb_ack = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge i_clk);
      if (o_mack[2]) acks++;
      chk("t2_ack_others", {62'd0, o_mack[1:0]}, 64'd0);
      nxt();
    end
    i_wb_ack = 1'b0;
    chk("t2_ack_count", 64'(acks), 64'd3);

    // Throttle: three outstanding fill the counter, the fourth is held
    issue(2, 30'h0000_0b00);
    issue(2, 30'h0000_0b01);
    issue(2, 30'h0000_0b02);
    i_maddr[2*AW +: AW] = 30'h0000_0b03;
    exp_q.push_back(30'h0000_0b03);
    @(negedge i_clk);
    chk("t4_held_stall", {63'd0, o_mstall[2]}, 64'd1);
    chk("t4_held_stb", {63'd0, o_wb_gbl_stb}, 64'd0);
    nxt();
    i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("t4_ackcyc_stall", {63'd0, o_mstall[2]}, 64'd1);
    chk("t4_ackcyc_mack", {61'd0, o_mack}, 64'h4);
    nxt();
    i_wb_ack = 1'b0;
    @(negedge i_clk);
    chk("t4_released_stall", {63'd0, o_mstall[2]}, 64'd0);
    chk("t4_released_stb", {63'd0, o_wb_gbl_stb}, 64'd1);
    nxt();
    i_mstb_gbl = 3'b000;

    // Error with two outstanding, then stale acks are dropped
    i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("t5_ack", {61'd0, o_mack}, 64'h4);
    nxt();
    i_wb_ack = 1'b0;
    i_wb_err = 1'b1;
    @(negedge i_clk);
    chk("t5_merr", {61'd0, o_merr}, 64'h4);
    chk("t5_err_noack", {61'd0, o_mack}, 64'd0);
    nxt();
    i_wb_err = 1'b0;
    i_wb_ack = 1'b1;
    @(negedge i_clk);
    chk("t5_merr_one_cycle", {61'd0, o_merr}, 64'd0);
    chk("t5_cnt_cleared", {61'd0, o_mack}, 64'd0);
    nxt();
    i_mcyc_gbl = 3'b000;
    @(negedge i_clk);
    chk("t5_late_ack", {61'd0, o_mack}, 64'd0);
    chk("t5_late_gcyc", {63'd0, o_wb_gbl_cyc}, 64'd0);
    nxt();
    i_wb_ack = 1'b0;

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
